// File: rtl/boot_pkg.sv
// Shared types and constants for the program-load/run controller.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_HALT,
    ST_TMO
  } boot_state_t;

  // jal x0,0 -- the program parks itself on this self-loop when finished
  localparam logic [31:0] HALT_INSN = 32'h0000_006f;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Load port between the host loader (master) and the boot sequencer (slave).
interface boot_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            ld_valid;
  logic            ld_ready;
  logic            ld_sel;
  logic [15:0]     ld_addr;
  logic [XLEN-1:0] ld_data;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data,
    output ld_ready
  );

endinterface

// File: rtl/boot_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Program-load and run controller: loads imem/dmem, holds then releases the core, watches for halt/timeout.
// Optional load checksum enabled by defining BOOT_CHECKSUM_EN.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter int unsigned DMEM_DEPTH  = 64,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
  localparam int unsigned DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  boot_sequencer_if.slave   ld,
  input  logic              start,
  input  logic              clear,
  output logic              imem_we,
  output logic [IA_W-1:0]   imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              dmem_we,
  output logic [DA_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic              core_rst,
  input  logic [XLEN-1:0]   instr_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err_oob,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [XLEN-1:0]   checksum
);

  localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

  boot_state_t     state, state_nxt;
  logic            ready_q;
  logic            accept, sel_dmem, in_range;
  logic            clr_flags, enter_hold, is_halt, tmo_hit;
  logic [HC_W-1:0] hold_q;

  assign ld.ld_ready = ready_q;

  always_comb begin
    accept     = ready_q && ld.ld_valid;
    sel_dmem   = (ld.ld_sel == SEL_DMEM);
    in_range   = sel_dmem ? addr_in_range(ld.ld_addr, DMEM_DEPTH)
                          : addr_in_range(ld.ld_addr, IMEM_DEPTH);
    clr_flags  = clear && ((state == ST_IDLE) || (state == ST_HALT) || (state == ST_TMO));
    is_halt    = (instr_in == XLEN'(HALT_INSN));
    tmo_hit    = (cycle_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_HOLD;
      ST_HOLD: if (hold_q == HC_W'(HOLD_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (is_halt)      state_nxt = ST_HALT;
        else if (tmo_hit) state_nxt = ST_TMO;
      end
      ST_HALT, ST_TMO: begin
        if (clear)      state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
    enter_hold = (state_nxt == ST_HOLD) && (state != ST_HOLD);
  end

  // HOLD length counter idles at zero outside HOLD; cycle counter zeroes on HOLD entry
  sat_counter #(.WIDTH(HC_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_HOLD),
    .inc (state == ST_HOLD),
    .q   (hold_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_hold),
    .inc (state == ST_RUN),
    .q   (cycle_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err_oob    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      ready_q  <= (state_nxt == ST_IDLE);
      core_rst <= (state_nxt != ST_RUN);
      busy     <= (state_nxt == ST_HOLD) || (state_nxt == ST_RUN);
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;

      if (clr_flags || enter_hold) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
      if (clr_flags) err_oob <= 1'b0;

      // a beat accepted alongside clear still reports its own range error
      if (accept) begin
        if (!in_range) begin
          err_oob <= 1'b1;
        end else if (sel_dmem) begin
          dmem_we    <= 1'b1;
          dmem_addr  <= ld.ld_addr[DA_W-1:0];
          dmem_wdata <= ld.ld_data;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= ld.ld_addr[IA_W-1:0];
          imem_wdata <= ld.ld_data;
        end
      end

      if (state == ST_RUN) begin
        if (state_nxt == ST_HALT) done    <= 1'b1;
        if (state_nxt == ST_TMO)  timeout <= 1'b1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [XLEN-1:0] cks_base;

  // clear zeroes the running value before a same-cycle beat folds in
  always_comb cks_base = clr_flags ? '0 : checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept && in_range) begin
      checksum <= {cks_base[XLEN-2:0], cks_base[XLEN-1]} ^ ld.ld_data;
    end else begin
      checksum <= cks_base;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
